// File: rtl/click_classifier.sv
// Groups debounced press pulses into single/double/triple click gestures.
// Optional macro CLICK_TRIPLE_EN enables the third-click state; without it two clicks classify as double.
module click_classifier #(
    parameter int WINDOW_CYCLES = 20,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clean_pulse,
    output logic                   single_click,
    output logic                   double_click,
    output logic                   triple_click,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] click_total
);

    localparam int TW = $clog2(WINDOW_CYCLES + 1);
    // Timer value on the edge that closes the window (E0+WINDOW_CYCLES).
    localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);

`ifdef CLICK_TRIPLE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT1 = 2'd1, WAIT2 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT1 = 2'd1} state_t;
`endif

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   single_q, single_d;
    logic                   double_q, double_d;
    logic                   triple_q, triple_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] total_q, total_d;
    logic                   expired_s;

    assign expired_s = (timer_q == TIMER_LAST);

    // Next-state, window timer and classification pulse logic.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        single_d = 1'b0;
        double_d = 1'b0;
        triple_d = 1'b0;
        total_d  = total_q;
        case (state_q)
            IDLE: begin
                if (clean_pulse) begin
                    state_d = WAIT1;
                    timer_d = '0;
                end else begin
                    timer_d = '0;
                end
            end
            WAIT1: begin
                if (clean_pulse) begin
`ifdef CLICK_TRIPLE_EN
                    state_d = WAIT2;
                    timer_d = '0;
`else
                    state_d  = IDLE;
                    timer_d  = '0;
                    double_d = 1'b1;
`endif
                end else if (expired_s) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    single_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef CLICK_TRIPLE_EN
            WAIT2: begin
                // A third click classifies immediately; no need to wait out the window.
                if (clean_pulse) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    triple_d = 1'b1;
                end else if (expired_s) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    double_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        if (single_d || double_d || triple_d) begin
            total_d = total_q + COUNT_WIDTH'(1);
        end else begin
            total_d = total_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            busy_q   <= 1'b0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            single_q <= single_d;
            double_q <= double_d;
            triple_q <= triple_d;
            busy_q   <= busy_d;
            total_q  <= total_d;
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign triple_click = triple_q;
    assign busy         = busy_q;
    assign click_total  = total_q;

endmodule

// File: tb/tb_click_classifier.sv
// Bench for click_classifier: directed scenarios plus random pulses against a gesture-level model.
module tb_click_classifier;

    localparam int W  = 8;
    localparam int CW = 3;
`ifdef CLICK_TRIPLE_EN
    localparam int MAXC = 3;
`else
    localparam int MAXC = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clean_pulse = 1'b0;
    logic          single_click, double_click, triple_click, busy;
    logic [CW-1:0] click_total;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: clicks in current gesture, edge index of last click, gesture count.
    int m_clicks = 0;
    int m_last   = 0;
    int m_n      = 0;
    int m_total  = 0;
    bit e_s, e_d, e_t;

    click_classifier #(.WINDOW_CYCLES(W), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .clean_pulse(clean_pulse),
        .single_click(single_click), .double_click(double_click),
        .triple_click(triple_click), .busy(busy), .click_total(click_total)
    );

    always #5 clk = ~clk;

    task automatic classify();
        case (m_clicks)
            1: e_s = 1'b1;
            2: e_d = 1'b1;
            3: e_t = 1'b1;
            default: ;
        endcase
        m_total  = (m_total + 1) % (1 << CW);
        m_clicks = 0;
    endtask

    // Drive one edge and advance the gesture model to what should be visible after it.
    task automatic step(input bit p, input bit r);
        @(negedge clk);
        clean_pulse = p;
        reset_n     = r;
        @(posedge clk);
        #1;
        m_n++;
        e_s = 1'b0; e_d = 1'b0; e_t = 1'b0;
        if (!r) begin
            m_clicks = 0;
            m_total  = 0;
        end else if (m_clicks == 0) begin
            if (p) begin
                m_clicks = 1;
                m_last   = m_n;
            end
        end else if (p) begin
            m_clicks++;
            m_last = m_n;
            if (m_clicks == MAXC) classify();
        end else if (m_n - m_last == W) begin
            classify();
        end
    endtask

    function automatic logic [CW+3:0] exp_vec();
        return {e_s, e_d, e_t, (m_clicks != 0), CW'(m_total)};
    endfunction

    task automatic do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({single_click, double_click, triple_click, busy, click_total} !== 7'b0) begin
            $display("FAIL reset got=%b want=%b", {single_click, double_click, triple_click, busy, click_total}, 7'b0);
        end else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step(e == 10, 1'b1);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL single e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
            if (e == 18) begin
                n_checks++;
                if (single_click !== 1'b1 || click_total !== 3'd1) begin
                    $display("FAIL single_at18 got=%b/%0d want=1/1", single_click, click_total);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_double_boundary();
        do_reset();
        for (int e = 1; e <= 35; e++) begin
            step(e == 10 || e == 18, 1'b1);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL double_edge e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
        do_reset();
        for (int e = 1; e <= 35; e++) begin
            step(e == 10 || e == 19, 1'b1);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL double_late e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
    endtask

    task automatic test_triple();
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step(e == 10 || e == 13 || e == 15 || e == 16, 1'b1);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL triple e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step(e == 10, !(e == 13 || e == 14));
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL reset_mid e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int e = 1; e <= 106; e++) begin
            step(e >= 10 && ((e - 10) % 12 == 0) && e < 106, 1'b1);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL wrap e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
        n_checks++;
        if (click_total !== 3'd0) begin
            $display("FAIL wrap_total got=%0d want=0", click_total);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step(e == 10 || e == 12, 1'b1);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL fast e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int e = 1; e <= 3000; e++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 99) != 0);
            n_checks++;
            if ({single_click, double_click, triple_click, busy, click_total} !== exp_vec()) begin
                $display("FAIL random e=%0d got=%b want=%b", e, {single_click, double_click, triple_click, busy, click_total}, exp_vec());
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double_boundary();
        test_triple();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/click_classifier.md
CLICK_CLASSIFIER -- requirements
Module: click_classifier

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 20: maximum spacing in clk cycles between consecutive clicks of one gesture; legal range >= 2.
REQ-002 SHALL have parameter COUNT_WIDTH, default 8: width of click_total.
REQ-003 SHALL have port clk  input  1: the block's only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port clean_pulse  input  1: single-cycle press event from the upstream debouncer in the same clk domain.
REQ-006 SHALL have port single_click  output  1: one-cycle pulse; the gesture was one click.
REQ-007 SHALL have port double_click  output  1: one-cycle pulse; the gesture was two clicks.
REQ-008 SHALL have port triple_click  output  1: one-cycle pulse; the gesture was three clicks.
REQ-009 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-010 SHALL have port click_total  output  COUNT_WIDTH: count of classified gestures.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT1 (one click seen) and WAIT2 (two clicks seen), plus a window timer of width $clog2(WINDOW_CYCLES+1).
REQ-012 SHALL, in IDLE, on a sampled clean_pulse: enter WAIT1 and clear the timer; with no pulse, stay in IDLE.
REQ-013 SHALL count a pulse as part of the gesture when it is sampled at any edge E0+1 .. E0+WINDOW_CYCLES, where E0 is the edge that sampled the previous click.
REQ-014 SHALL, in WAIT1, on an in-window pulse: enter WAIT2 and clear the timer.
REQ-015 SHALL, in WAIT1, at edge E0+WINDOW_CYCLES with no pulse: return to IDLE and assert single_click for the following cycle.
REQ-016 SHALL, in WAIT2, at edge E0+WINDOW_CYCLES with no pulse: return to IDLE and assert double_click for the following cycle.
REQ-017 SHALL, in WAIT2, on an in-window pulse sampled at edge E: return to IDLE and assert triple_click for the cycle after E, with no extra window wait.
REQ-018 SHALL, when a pulse and timer expiry fall on the same edge, treat the pulse as in-window; the pulse wins.
REQ-019 SHALL accept a pulse sampled on the edge immediately after a classification as the first click of a new gesture.
REQ-020 SHALL drive all outputs from registers; at most one of single/double/triple_click is high in any cycle, and each is high for exactly one cycle.
REQ-021 SHALL increment click_total by 1 on the same edge that asserts any classification pulse; it wraps from 2^COUNT_WIDTH-1 to 0.
REQ-022 SHALL assume clean_pulse is never high on two consecutive cycles; if it is, each high cycle counts as a separate click.

Reset
REQ-023 SHALL, on any edge with reset_n low, set state to IDLE, timer to 0, all click pulses to 0, busy to 0 and click_total to 0.
REQ-024 SHALL ignore clean_pulse on edges where reset_n is low.
REQ-025 SHALL discard any gesture in progress when reset arrives mid-WAIT1/WAIT2, and emit no classification pulse for it.
REQ-026 SHALL clear a classification pulse that is already high if reset_n is low at the next edge.

Configuration
REQ-027 SHALL support macro CLICK_TRIPLE_EN.
REQ-028 SHALL, with CLICK_TRIPLE_EN defined, behave exactly as REQ-011..REQ-022.
REQ-029 SHALL, without CLICK_TRIPLE_EN: omit WAIT2; an in-window pulse in WAIT1 asserts double_click in the next cycle and returns to IDLE; triple_click is tied to 0.

Verification
REQ-030 SHALL run the bench with WINDOW_CYCLES=8, COUNT_WIDTH=3 and CLICK_TRIPLE_EN defined unless a scenario states otherwise.
REQ-031 SHALL cover single click: pulse at edge 10 -> single_click high only in the cycle after edge 18, busy high for edges 10..17, click_total=1.
REQ-032 SHALL cover double click at the boundary: pulses at edges 10 and 18 -> no single_click; double_click after edge 26; a pulse at 19 instead of 18 -> single_click after 18, then a new gesture.
REQ-033 SHALL cover triple click: pulses at edges 10, 13 and 15 -> triple_click in the cycle after edge 15, busy low after edge 15; a pulse at edge 16 starts a new gesture.
REQ-034 SHALL cover reset mid-gesture: pulse at edge 10, reset_n low at edges 13..14 -> no classification pulse, click_total=0, busy=0 from edge 13.
REQ-035 SHALL cover wrap and build: 8 single gestures -> click_total returns to 0; without CLICK_TRIPLE_EN, pulses at edges 10 and 12 -> double_click after edge 12, triple_click never high.
